// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed, XOR-checksummed byte stream,
// packs it into big-endian 32-bit words, writes them into instruction memory,
// and holds the CPU fetch path in reset until a complete, good image is loaded.
//
// Stream format: LEN_HI LEN_LO (word count), 4*len data bytes, 1 checksum byte.
// The checksum is the XOR of the data bytes only.
module imem_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_byte,
   output logic              in_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_waddr,
   output logic [31:0]       im_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // Capacity in words; the word counter needs one extra bit so it can
   // reach MAX_WORDS itself when the memory is filled completely.
   localparam int          MAX_WORDS = 2 ** (ADDR_W - 2);
   localparam int          WC_W      = ADDR_W - 1;
   localparam logic [16:0] MAX_LEN   = 17'(MAX_WORDS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

   state_t          state_reg;
   logic [15:0]     len_reg;
   logic [WC_W-1:0] word_count_reg;
   logic [1:0]      byte_idx_reg;
   logic [7:0]      csum_reg;
   // First three bytes of the word being assembled, oldest byte on top.
   logic [23:0]     word_buf_reg;

   logic            accept;
   logic [WC_W-1:0] word_count_next;
   logic [16:0]     len_rx;
   logic            last_word;
   logic [7:0]      csum_next;

   // Handshake decode and helper values shared by the FSM.
   always_comb begin
      accept          = in_valid & in_ready;
      word_count_next = word_count_reg + 1'b1;
      // Full length as it stands once the LEN_LO byte lands.
      len_rx          = {1'b0, len_reg[15:8], in_byte};
      // True on the 4th byte of the final word of the image.
      last_word       = (17'(word_count_next) == {1'b0, len_reg});
      csum_next       = csum_reg ^ in_byte;
   end

   // Loader FSM: all outputs are registered and change with the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= S_IDLE;
         len_reg        <= '0;
         word_count_reg <= '0;
         byte_idx_reg   <= '0;
         csum_reg       <= '0;
         word_buf_reg   <= '0;
         in_ready       <= 1'b0;
         im_we          <= 1'b0;
         im_waddr       <= '0;
         im_wdata       <= '0;
         cpu_hold       <= 1'b1;
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
      end else begin
         // Write strobe is a single-cycle pulse unless re-armed below.
         im_we <= 1'b0;

         case (state_reg)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state_reg      <= S_LEN_HI;
                  in_ready       <= 1'b1;
                  cpu_hold       <= 1'b1;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  err            <= 1'b0;
                  word_count_reg <= '0;
                  byte_idx_reg   <= '0;
                  csum_reg       <= '0;
               end
            end

            S_LEN_HI: begin
               if (accept) begin
                  len_reg[15:8] <= in_byte;
                  state_reg     <= S_LEN_LO;
               end
            end

            S_LEN_LO: begin
               if (accept) begin
                  len_reg[7:0] <= in_byte;
                  if (len_rx > MAX_LEN) begin
                     // Image cannot fit: reject before touching memory.
                     state_reg <= S_ERR;
                     in_ready  <= 1'b0;
                     busy      <= 1'b0;
                     err       <= 1'b1;
                  end else if (len_rx == 17'd0) begin
                     state_reg <= S_CHK;
                  end else begin
                     state_reg <= S_DATA;
                  end
               end
            end

            S_DATA: begin
               if (accept) begin
                  csum_reg     <= csum_next;
                  byte_idx_reg <= byte_idx_reg + 2'd1;
                  if (byte_idx_reg == 2'd3) begin
                     im_we          <= 1'b1;
                     im_waddr       <= {word_count_reg[ADDR_W-3:0], 2'b00};
                     im_wdata       <= {word_buf_reg, in_byte};
                     word_count_reg <= word_count_next;
                     if (last_word) begin
                        state_reg <= S_CHK;
                     end
                  end else begin
                     word_buf_reg <= {word_buf_reg[15:0], in_byte};
                  end
               end
            end

            S_CHK: begin
               if (accept) begin
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
                  if (in_byte == csum_reg) begin
                     // Good image: release the CPU.
                     state_reg <= S_DONE;
                     done      <= 1'b1;
                     cpu_hold  <= 1'b0;
                  end else begin
                     // Bad image: words already written stay, CPU stays held.
                     state_reg <= S_ERR;
                     err       <= 1'b1;
                  end
               end
            end

            default: begin
               state_reg <= S_IDLE;
               in_ready  <= 1'b0;
               busy      <= 1'b0;
               cpu_hold  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven loads with a write scoreboard, plus hand-written
// sequences for a full-capacity image and reset in the middle of a load.
module tb_imem_loader;

   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_byte = 8'h00;
   logic              in_ready;
   logic              im_we;
   logic [ADDR_W-1:0] im_waddr;
   logic [31:0]       im_wdata;
   logic              cpu_hold;
   logic              busy;
   logic              done;
   logic              err;

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_valid (in_valid),
      .in_byte  (in_byte),
      .in_ready (in_ready),
      .im_we    (im_we),
      .im_waddr (im_waddr),
      .im_wdata (im_wdata),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string            name;
      int               nbytes;
      logic [0:11][7:0] bytes;
      int               gap;
      logic             exp_done;
      logic             exp_err;
      int               exp_writes;
   } vec_t;

   vec_t vecs [0:5];

   int checks = 0;
   int failures = 0;
   int wr_count = 0;

   // Scoreboard entries: {address, data}.
   logic [ADDR_W+31:0] exp_q [$];
   logic [ADDR_W+31:0] mon_e;
   logic [31:0]        last_wdata;
   logic [ADDR_W-1:0]  last_waddr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Write monitor: every im_we pulse is matched against the scoreboard.
   always @(negedge clk) begin
      if (im_we === 1'b1) begin
         wr_count++;
         $display("write addr=0x%03h data=0x%08h", im_waddr, im_wdata);
         if (exp_q.size() == 0) begin
            check("write_expected", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_e = exp_q.pop_front();
            check("im_waddr", 32'(im_waddr), 32'(mon_e[ADDR_W+31:32]));
            check("im_wdata", im_wdata, mon_e[31:0]);
         end
      end
   end

   // Push the expected write for a word whose 4th byte is about to be driven.
   task automatic push_word(input int word_idx, input logic [31:0] w);
      logic [ADDR_W-1:0] a;
      a = ADDR_W'(word_idx * 4);
      exp_q.push_back({a, w});
      last_waddr = a;
      last_wdata = w;
   endtask

   task automatic start_load();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("hold_after_start", 32'(cpu_hold), 32'd1);
      check("done_after_start", 32'(done), 32'd0);
      check("err_after_start", 32'(err), 32'd0);
      check("ready_after_start", 32'(in_ready), 32'd1);
   endtask

   // Offer one byte and keep it valid until the DUT accepts it (bounded).
   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_byte  = b;
      for (int t = 0; t < 50 && !ok; t++) begin
         if (in_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!ok) check("in_ready_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic check_end(input string name, input logic exp_done, input logic exp_err,
                            input int exp_writes, input int wr0);
      repeat (2) begin @(posedge clk); #1; end
      check({name, "_done"}, 32'(done), 32'(exp_done));
      check({name, "_err"}, 32'(err), 32'(exp_err));
      check({name, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
      check({name, "_busy"}, 32'(busy), 32'd0);
      check({name, "_in_ready"}, 32'(in_ready), 32'd0);
      check({name, "_writes"}, 32'(wr_count - wr0), 32'(exp_writes));
      check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
      if (exp_writes > 0) begin
         check({name, "_wdata_hold"}, im_wdata, last_wdata);
         check({name, "_waddr_hold"}, 32'(im_waddr), 32'(last_waddr));
      end
      $display("load %s: writes=%0d done=%b err=%b cpu_hold=%b", name, wr_count - wr0, done, err, cpu_hold);
      exp_q.delete();
   endtask

   task automatic run_vec(input vec_t v);
      int wr0;
      int len;
      wr0 = wr_count;
      start_load();
      len = int'({v.bytes[0], v.bytes[1]});
      for (int i = 0; i < v.nbytes; i++) begin
         int d;
         d = i - 2;
         if (d >= 0 && d < 4 * len && d % 4 == 3)
            push_word(d / 4, {v.bytes[i-3], v.bytes[i-2], v.bytes[i-1], v.bytes[i]});
         send_byte(v.bytes[i]);
         if (v.gap > 0 && i < v.nbytes - 1) begin
            // A start pulse in the middle of DATA must be ignored.
            if (i == 6) start = 1'b1;
            repeat (v.gap) begin
               @(posedge clk); #1;
               start = 1'b0;
            end
         end
      end
      check_end(v.name, v.exp_done, v.exp_err, v.exp_writes, wr0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          wr0;
      logic [7:0]  csum;
      logic [31:0] w;

      vecs[0] = '{"basic", 11, '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h3C, 8'h01, 8'hAB, 8'hCD, 8'h76, 8'h00},
                  0, 1'b1, 1'b0, 2};
      vecs[1] = '{"empty", 3, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  0, 1'b1, 1'b0, 0};
      vecs[2] = '{"too_long", 2, '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  0, 1'b0, 1'b1, 0};
      vecs[3] = '{"bad_chk", 11, '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h3C, 8'h01, 8'hAB, 8'hCD, 8'h77, 8'h00},
                  0, 1'b0, 1'b1, 2};
      vecs[4] = '{"gapped", 11, '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h3C, 8'h01, 8'hAB, 8'hCD, 8'h76, 8'h00},
                  1, 1'b1, 1'b0, 2};
      vecs[5] = '{"one_word", 7, '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  0, 1'b1, 1'b0, 1};

      // Reset values.
      repeat (3) begin @(posedge clk); end
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_im_we", 32'(im_we), 32'd0);
      check("rst_im_waddr", 32'(im_waddr), 32'd0);
      check("rst_im_wdata", im_wdata, 32'd0);
      check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Full-capacity image: 256 words, last address 0x3FC.
      wr0  = wr_count;
      csum = 8'h00;
      start_load();
      send_byte(8'h01);
      send_byte(8'h00);
      for (int k = 0; k < 256; k++) begin
         w = $urandom;
         csum = csum ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
         send_byte(w[31:24]);
         send_byte(w[23:16]);
         send_byte(w[15:8]);
         push_word(k, w);
         send_byte(w[7:0]);
      end
      send_byte(csum);
      check("full_last_addr", 32'(last_waddr), 32'h3FC);
      check_end("full", 1'b1, 1'b0, 256, wr0);

      // Reset after the 6th data byte: word 1 must never be written.
      wr0 = wr_count;
      start_load();
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h20);
      send_byte(8'h08);
      send_byte(8'h00);
      push_word(0, 32'h2008_0005);
      send_byte(8'h05);
      send_byte(8'h3C);
      send_byte(8'h01);
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      check("mid_rst_im_we", 32'(im_we), 32'd0);
      check("mid_rst_im_waddr", 32'(im_waddr), 32'd0);
      check("mid_rst_im_wdata", im_wdata, 32'd0);
      check("mid_rst_cpu_hold", 32'(cpu_hold), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_err", 32'(err), 32'd0);
      repeat (3) begin @(posedge clk); end
      #1;
      rst_n = 1'b1;
      repeat (3) begin @(posedge clk); end
      #1;
      check("mid_rst_writes", 32'(wr_count - wr0), 32'd1);
      check("mid_rst_sb_empty", 32'(exp_q.size()), 32'd0);
      $display("load mid_reset: writes=%0d", wr_count - wr0);
      run_vec(vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Write-side counterpart to instruction fetch: receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Writes those words into the instruction memory through a word-wide write port. Holds the PC/fetch path in reset (cpu_hold) until a complete, checksum-verified program image is loaded. Sits between the host/UART byte source and the instruction memory.

Parameters:
ADDR_W, 10, instruction memory byte-address width; capacity MAX_WORDS = 2**ADDR_W / 4 (256 at default)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin a new load
in_valid  in  1  in_byte is valid
in_byte  in  8  stream byte
in_ready  out  1  loader can accept a byte this cycle
im_we  out  1  one-cycle instruction-memory write strobe
im_waddr  out  ADDR_W  word-aligned byte address (bits [1:0] always 0)
im_wdata  out  32  word to write
cpu_hold  out  1  1 = keep PC/fetch in reset
busy  out  1  load in progress
done  out  1  last load completed with good checksum (sticky until next start)
err  out  1  last load failed (length or checksum; sticky until next start)

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: in_ready=0, im_we=0, im_waddr=0, im_wdata=0, cpu_hold=1, busy=0, done=0, err=0.
  - State IDLE; counters and checksum cleared.
- Byte accepted only on a cycle with in_valid & in_ready.
- in_ready=1 exactly in states LEN_HI, LEN_LO, DATA, CHK.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR.
  - IDLE/DONE/ERR + start -> LEN_HI. Same edge: cpu_hold=1, busy=1, done=0, err=0, word counter=0, byte index=0, checksum=0.
  - start in any other state is ignored.
  - LEN_HI: accepted byte -> len[15:8]; go LEN_LO.
  - LEN_LO: accepted byte -> len[7:0].
    - If full len > MAX_WORDS -> ERR.
    - Else if len==0 -> CHK.
    - Else -> DATA.
  - DATA:
    - Each accepted byte XORs into the 8-bit checksum.
    - Byte index 0..3 maps to word bits [31:24],[23:16],[15:8],[7:0] (big-endian, MIPS order).
    - On the accept of byte index 3, next edge: im_we=1 for exactly one cycle, im_waddr = word_count*4, im_wdata = assembled word; word_count increments.
    - After the last word's 4th byte -> CHK.
  - CHK: accepted byte compared with the running XOR.
    - Equal -> DONE: done=1, cpu_hold=0, busy=0.
    - Unequal -> ERR: err=1, cpu_hold stays 1, busy=0.
  - ERR -> in_ready=0, cpu_hold=1; leave only on start.
- Write latency: im_we asserts the cycle after the 4th byte of the word is accepted. Address wraps never (length check guarantees word_count < MAX_WORDS).
- Back-to-back bytes every cycle are supported; gaps (in_valid=0) stall with no state change.
- Words written before a checksum failure remain in memory; cpu_hold keeps them from executing.
- Reset mid-load aborts immediately: no further im_we, all outputs to reset values.
- im_wdata/im_waddr hold their last value when im_we=0.

Test Plan:
1. start; bytes 00 02 20 08 00 05 3C 01 AB CD 76 at one per cycle -> im_we pulses twice: (addr 0x000, 0x20080005) then (addr 0x004, 0x3C01ABCD); then done=1, cpu_hold=0, err=0, busy=0.
2. start; bytes 00 00 00 -> no im_we, done=1, cpu_hold=0.
3. start; bytes 01 01 (len 257 > 256) -> ERR after 2nd byte; in_ready=0, err=1, cpu_hold=1, no im_we; a later start clears err.
4. Same stream as test 1 with last byte 77 -> both words written, err=1, done=0, cpu_hold=1.
5. Test 1 stream with in_valid toggled 1/0 each cycle -> identical writes and result; no byte lost or duplicated; start pulsed mid-DATA is ignored.
6. rst_n low after 6th data byte of test 1 -> im_we never pulses for word 1; all outputs at reset values; new full load then succeeds.
